// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Byte-serial instruction fetch. Assembles little-endian 32-bit
//            words, hands them to decode over valid/ready and accepts
//            branch redirects. Optional HALT detection: FETCH_HALT_DETECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
  parameter int              PC_W     = 64,
  parameter int              AW       = 12,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            fetch_en,
  output logic            imem_req,
  output logic [AW-1:0]   imem_addr,
  input  logic            imem_ack,
  input  logic [7:0]      imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [PC_W-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            halted
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    PRESENT = 3'd2,
    FLUSH   = 3'd3,
    HALTED  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       word_q, word_d;
  logic [PC_W-1:0]   instr_pc_q, instr_pc_d;
  logic              halted_q, halted_d;
  logic [AW-1:0]     flush_addr_q, flush_addr_d;

  logic [PC_W-1:0]   redir_pc;
  logic [AW-1:0]     fetch_addr;
  logic              accept;
  logic              halt_hit;
  logic              unused_redirect_lsbs;

  assign redir_pc             = {redirect_pc[PC_W-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign fetch_addr           = pc_q[AW-1:0] + AW'(byte_idx_q);
  assign accept               = (state_q == PRESENT) && instr_ready;

`ifdef FETCH_HALT_DETECT_EN
  assign halt_hit = (word_q[31:21] == 11'h7FF);
`else
  assign halt_hit = 1'b0;
`endif

  assign instr_valid = (state_q == PRESENT);
  assign instr       = word_q;
  assign instr_pc    = instr_pc_q;
  assign halted      = halted_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    instr_pc_d   = instr_pc_q;
    halted_d     = halted_q;
    flush_addr_d = flush_addr_q;
    imem_req     = 1'b0;
    imem_addr    = '0;

    case (state_q)
      IDLE: begin
        if (redirect_valid) pc_d = redir_pc;
        if (fetch_en) begin
          state_d    = FETCH;
          byte_idx_d = 2'd0;
        end
      end

      FETCH: begin
        imem_req  = 1'b1;
        imem_addr = fetch_addr;
        if (redirect_valid) begin
          pc_d       = redir_pc;
          byte_idx_d = 2'd0;
          // An un-acked read must still complete; remember its address.
          if (!imem_ack) begin
            state_d      = FLUSH;
            flush_addr_d = fetch_addr;
          end
        end else if (imem_ack) begin
          word_d[{byte_idx_q, 3'b000} +: 8] = imem_rdata;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d    = PRESENT;
            instr_pc_d = pc_q;
          end
        end
      end

      FLUSH: begin
        imem_req  = 1'b1;
        imem_addr = flush_addr_q;
        if (redirect_valid) pc_d = redir_pc;
        if (imem_ack) begin
          state_d    = FETCH;
          byte_idx_d = 2'd0;
        end
      end

      PRESENT: begin
        if (accept) begin
          if (halt_hit) begin
            halted_d = 1'b1;
            state_d  = HALTED;
          end else begin
            pc_d    = redirect_valid ? redir_pc : pc_q + PC_W'(4);
            state_d = fetch_en ? FETCH : IDLE;
          end
        end else if (redirect_valid) begin
          pc_d    = redir_pc;
          state_d = FETCH;
        end
      end

      HALTED: begin
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      byte_idx_q   <= 2'd0;
      word_q       <= 32'd0;
      instr_pc_q   <= '0;
      halted_q     <= 1'b0;
      flush_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      instr_pc_q   <= instr_pc_d;
      halted_q     <= halted_d;
      flush_addr_q <= flush_addr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Directed bench for fetch_sequencer with a byte memory model
//            whose ack latency is programmable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  logic        clk;
  logic        reset_n;
  logic        fetch_en;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ack;
  logic [7:0]  imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halted;

  logic [7:0]  mem [0:4095];
  logic [3:0]  wait_cnt;
  logic [3:0]  ack_delay;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(.PC_W(64), .AW(12), .RESET_PC(64'd0)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fetch_en       (fetch_en),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory acks after ack_delay idle cycles of an asserted request.
  assign imem_ack   = imem_req && (wait_cnt == ack_delay);
  assign imem_rdata = mem[imem_addr];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  wait_cnt <= 4'd0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 4'd1;
    else                           wait_cnt <= 4'd0;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[0]     = 8'h78; mem[1]     = 8'h56; mem[2]     = 8'h34; mem[3]     = 8'h12;
    mem[4]     = 8'h11; mem[5]     = 8'h22; mem[6]     = 8'h33; mem[7]     = 8'h44;
    mem[8]     = 8'hFF; mem[9]     = 8'hFF; mem[10]    = 8'hFF; mem[11]    = 8'hFF;
    mem[12'h40] = 8'h0D; mem[12'h41] = 8'h0C; mem[12'h42] = 8'h0B; mem[12'h43] = 8'h0A;
    mem[12'h100] = 8'hEF; mem[12'h101] = 8'hBE; mem[12'h102] = 8'hAD; mem[12'h103] = 8'hDE;

    reset_n        = 1'b0;
    fetch_en       = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    ack_delay      = 4'd0;

    tick(2);
    check("rst_req",      64'(imem_req),    64'd0);
    check("rst_addr",     64'(imem_addr),   64'd0);
    check("rst_valid",    64'(instr_valid), 64'd0);
    check("rst_instr",    64'(instr),       64'd0);
    check("rst_instr_pc", instr_pc,         64'd0);
    check("rst_halted",   64'(halted),      64'd0);
    reset_n = 1'b1;
    tick(1);

    // Zero-wait fetch of the first word
    fetch_en    = 1'b1;
    instr_ready = 1'b1;
    tick(1);
    check("t1_req",  64'(imem_req),  64'd1);
    check("t1_addr", 64'(imem_addr), 64'd0);
    tick(3);
    check("t1_valid_early", 64'(instr_valid), 64'd0);
    tick(1);
    check("t1_valid", 64'(instr_valid), 64'd1);
    check("t1_instr", 64'(instr),       64'h12345678);
    check("t1_pc",    instr_pc,         64'd0);
    tick(1);
    check("t1_accepted", 64'(instr_valid), 64'd0);
    check("t1_next_req", 64'(imem_req),    64'd1);
    check("t1_next_addr", 64'(imem_addr),  64'd4);

    // Three wait cycles per byte
    ack_delay = 4'd3;
    tick(1);
    check("t2_addr_c1", 64'(imem_addr), 64'd4);
    check("t2_no_ack",  64'(imem_ack),  64'd0);
    tick(1);
    check("t2_addr_c2", 64'(imem_addr), 64'd4);
    tick(2);
    check("t2_addr_b1", 64'(imem_addr), 64'd5);
    instr_ready = 1'b0;
    tick(11);
    check("t2_valid_early", 64'(instr_valid), 64'd0);
    tick(1);
    check("t2_valid", 64'(instr_valid), 64'd1);
    check("t2_instr", 64'(instr),       64'h44332211);
    check("t2_pc",    instr_pc,         64'd4);

    // Decode stalls for five cycles
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_instr", 64'(instr),       64'h44332211);
      check("t3_hold_pc",    instr_pc,         64'd4);
      check("t3_no_req",     64'(imem_req),    64'd0);
      check("t3_hold_valid", 64'(instr_valid), 64'd1);
      tick(1);
    end
    check("t3_valid_c6", 64'(instr_valid), 64'd1);
    instr_ready = 1'b1;
    tick(1);
    check("t3_accepted", 64'(instr_valid), 64'd0);
    check("t3_req",      64'(imem_req),    64'd1);
    check("t3_addr",     64'(imem_addr),   64'd8);

    // Redirect while byte 2 of the word at 8 is outstanding
    tick(9);
    check("t4_addr_b2", 64'(imem_addr), 64'h00A);
    check("t4_no_ack",  64'(imem_ack),  64'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h102;
    tick(1);
    redirect_valid = 1'b0;
    check("t4_flush_req",  64'(imem_req),  64'd1);
    check("t4_flush_addr", 64'(imem_addr), 64'h00A);
    tick(1);
    check("t4_flush_ack_addr", 64'(imem_addr), 64'h00A);
    check("t4_flush_ack",      64'(imem_ack),  64'd1);
    tick(1);
    check("t4_new_addr", 64'(imem_addr), 64'h100);
    check("t4_new_req",  64'(imem_req),  64'd1);
    ack_delay = 4'd0;
    tick(4);
    check("t4_valid", 64'(instr_valid), 64'd1);
    check("t4_instr", 64'(instr),       64'hDEADBEEF);
    check("t4_pc",    instr_pc,         64'h100);

    // Accept and redirect in the same cycle
    redirect_valid = 1'b1;
    redirect_pc    = 64'h40;
    tick(1);
    redirect_valid = 1'b0;
    check("t5_consumed", 64'(instr_valid), 64'd0);
    check("t5_req",      64'(imem_req),    64'd1);
    check("t5_addr",     64'(imem_addr),   64'h040);
    tick(4);
    check("t5_valid", 64'(instr_valid), 64'd1);
    check("t5_instr", 64'(instr),       64'h0A0B0C0D);
    check("t5_pc",    instr_pc,         64'h40);
    fetch_en = 1'b0;
    tick(1);
    check("t5_idle_req",   64'(imem_req),    64'd0);
    check("t5_idle_valid", 64'(instr_valid), 64'd0);
    tick(2);
    check("t5_idle_req2", 64'(imem_req), 64'd0);

    // Restart from reset and run into the all-ones word at 8
    reset_n = 1'b0;
    #1;
    check("t6_rst_req",    64'(imem_req),    64'd0);
    check("t6_rst_halted", 64'(halted),      64'd0);
    tick(1);
    reset_n  = 1'b1;
    fetch_en = 1'b1;
    tick(15);
    check("t6_valid", 64'(instr_valid), 64'd1);
    check("t6_instr", 64'(instr),       64'hFFFFFFFF);
    check("t6_pc",    instr_pc,         64'd8);
    tick(1);
`ifdef FETCH_HALT_DETECT_EN
    check("t6_halted", 64'(halted),   64'd1);
    check("t6_no_req", 64'(imem_req), 64'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h40;
    tick(1);
    redirect_valid = 1'b0;
    tick(2);
    check("t6_halted_hold", 64'(halted),   64'd1);
    check("t6_no_req_hold", 64'(imem_req), 64'd0);
`else
    check("t6_not_halted", 64'(halted),    64'd0);
    check("t6_next_req",   64'(imem_req),  64'd1);
    check("t6_next_addr",  64'(imem_addr), 64'h00C);
`endif
    reset_n = 1'b0;
    #1;
    check("t6_clr_halted", 64'(halted),      64'd0);
    check("t6_clr_req",    64'(imem_req),    64'd0);
    check("t6_clr_valid",  64'(instr_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
